// File: rtl/ex_hazard_ctrl_if.sv
// Decode-side request and hazard-control response bundle for ex_hazard_ctrl.
// The front end drives the master side; the hazard controller is the slave.
interface ex_hazard_ctrl_if #(
    parameter int unsigned CNTW = 16
) ();
    logic            id_valid;
    logic [2:0]      id_rs;
    logic [2:0]      id_rt;
    logic            id_rs_used;
    logic            id_rt_used;
    logic [2:0]      id_rd;
    logic            id_wr;
    logic            id_load;
    logic            id_ctrl;
    logic            ex_redirect;
    logic            mem_stall;

    logic            stall_id;
    logic            flush;
    logic            ex_valid;
    logic            mem_valid;
    logic            wb_valid;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [2:0]      wb_rd;
    logic            wb_wr;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr, id_load,
               id_ctrl, ex_redirect, mem_stall,
        input  stall_id, flush, ex_valid, mem_valid, wb_valid, fwd_a, fwd_b, wb_rd, wb_wr,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr, id_load,
               id_ctrl, ex_redirect, mem_stall,
        output stall_id, flush, ex_valid, mem_valid, wb_valid, fwd_a, fwd_b, wb_rd, wb_wr,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: tracks EX/MEM/WB shadow records, detects
// load-use and redirect hazards, registers forwarding selects and counts stall/flush events.
module ex_hazard_ctrl #(
    parameter int unsigned CNTW = 16
) (
    input logic             clk,
    input logic             rst,
    ex_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       load;
        logic       ctrl;
        logic [2:0] rd;
    } stage_t;

    stage_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic redirect;
    logic load_use;
    logic stall_id;
    logic flush;

    // Nearer stage wins; a load still in EX cannot forward yet.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [2:0] src,
                                           input stage_t ex, input stage_t mem);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (ex.valid && ex.wr && !ex.load && ex.rd == src) begin
                sel = 2'b01;
            end else if (mem.valid && mem.wr && mem.rd == src) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        redirect = bus.ex_redirect & ex_q.valid & ex_q.ctrl;
        load_use = bus.id_valid & ex_q.valid & ex_q.load & ex_q.wr &
                   ((bus.id_rs_used & (bus.id_rs == ex_q.rd)) |
                    (bus.id_rt_used & (bus.id_rt == ex_q.rd)));
        // Priority mem_stall > redirect > load-use; reset masks everything.
        stall_id = rst & (bus.mem_stall | (load_use & ~redirect));
        flush    = rst & ~bus.mem_stall & redirect;
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (stall_id && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNTW'(1);
        end

        if (!bus.mem_stall) begin
            wb_d    = mem_q;
            mem_d   = ex_q;
            ex_d    = '0;
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
            if (bus.id_valid && !redirect && !load_use) begin
                ex_d    = '{valid: 1'b1, wr: bus.id_wr, load: bus.id_load,
                            ctrl: bus.id_ctrl, rd: bus.id_rd};
                fwd_a_d = fwd_sel(bus.id_rs_used, bus.id_rs, ex_q, mem_q);
                fwd_b_d = fwd_sel(bus.id_rt_used, bus.id_rt, ex_q, mem_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_id  = stall_id;
    assign bus.flush     = flush;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.mem_valid = mem_q.valid;
    assign bus.wb_valid  = wb_q.valid;
    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.wb_rd     = wb_q.rd;
    assign bus.wb_wr     = rst & wb_q.valid & wb_q.wr & ~bus.mem_stall;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios with literal expectations plus a randomized
// run, all outputs compared each cycle against a pipeline-list model.
module tb_ex_hazard_ctrl;
    localparam int unsigned CW   = 16;
    localparam int unsigned CW2  = 3;
    localparam int          SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.CNTW(CW))  bus ();
    ex_hazard_ctrl_if #(.CNTW(CW2)) bus2 ();

    ex_hazard_ctrl #(.CNTW(CW))  dut     (.clk(clk), .rst(rst),  .bus(bus));
    ex_hazard_ctrl #(.CNTW(CW2)) dut_sat (.clk(clk), .rst(rst2), .bus(bus2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pipe[0..2] = instruction records in EX, MEM, WB (oldest last).
    typedef struct packed {
        bit       v;
        bit       wr;
        bit       ld;
        bit       ct;
        bit [2:0] rd;
    } rec_t;

    rec_t   pipe [3];
    bit [1:0] m_fa, m_fb;
    int     m_scnt, m_fcnt;
    bit     model_on = 1'b0;

    function automatic bit m_redir();
        return bus.ex_redirect && pipe[0].v && pipe[0].ct;
    endfunction

    function automatic bit m_lu();
        return bus.id_valid && pipe[0].v && pipe[0].ld && pipe[0].wr &&
               ((bus.id_rs_used && bus.id_rs == pipe[0].rd) ||
                (bus.id_rt_used && bus.id_rt == pipe[0].rd));
    endfunction

    function automatic bit m_stall();
        return rst && (bus.mem_stall || (m_lu() && !m_redir()));
    endfunction

    function automatic bit m_flush();
        return rst && !bus.mem_stall && m_redir();
    endfunction

    function automatic bit [1:0] m_sel(input bit used, input bit [2:0] r);
        if (!used) return 2'd0;
        if (pipe[0].v && pipe[0].wr && !pipe[0].ld && pipe[0].rd == r) return 2'd1;
        if (pipe[1].v && pipe[1].wr && pipe[1].rd == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_enter();
        return bus.id_valid && !m_lu() && !m_redir();
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            pipe[0]  <= '0;
            pipe[1]  <= '0;
            pipe[2]  <= '0;
            m_fa     <= 2'd0;
            m_fb     <= 2'd0;
            m_scnt   <= 0;
            m_fcnt   <= 0;
            model_on <= 1'b1;
        end else begin
            if (m_stall() && m_scnt < SMAX) m_scnt <= m_scnt + 1;
            if (m_flush() && m_fcnt < SMAX) m_fcnt <= m_fcnt + 1;
            if (!bus.mem_stall) begin
                pipe[2] <= pipe[1];
                pipe[1] <= pipe[0];
                if (m_enter()) begin
                    pipe[0] <= '{v: 1'b1, wr: bus.id_wr, ld: bus.id_load, ct: bus.id_ctrl,
                                 rd: bus.id_rd};
                    m_fa    <= m_sel(bus.id_rs_used, bus.id_rs);
                    m_fb    <= m_sel(bus.id_rt_used, bus.id_rt);
                end else begin
                    pipe[0] <= '0;
                    m_fa    <= 2'd0;
                    m_fb    <= 2'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_stall_id",  bus.stall_id,  m_stall());
            chk("m_flush",     bus.flush,     m_flush());
            chk("m_ex_valid",  bus.ex_valid,  pipe[0].v);
            chk("m_mem_valid", bus.mem_valid, pipe[1].v);
            chk("m_wb_valid",  bus.wb_valid,  pipe[2].v);
            chk("m_wb_rd",     bus.wb_rd,     pipe[2].rd);
            chk("m_wb_wr",     bus.wb_wr,     rst && pipe[2].v && pipe[2].wr && !bus.mem_stall);
            chk("m_fwd_a",     bus.fwd_a,     m_fa);
            chk("m_fwd_b",     bus.fwd_b,     m_fb);
            chk("m_stall_cnt", bus.stall_cnt, m_scnt);
            chk("m_flush_cnt", bus.flush_cnt, m_fcnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input bit v, input bit [2:0] rs, input bit [2:0] rt, input bit rsu,
                         input bit rtu, input bit [2:0] rd, input bit wr, input bit ld,
                         input bit ct);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rs_used = rsu;
        bus.id_rt_used = rtu;
        bus.id_rd      = rd;
        bus.id_wr      = wr;
        bus.id_load    = ld;
        bus.id_ctrl    = ct;
    endtask

    task automatic nop();
        issue(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        rst2 = 1'b0;
        nop();
        bus.ex_redirect = 1'b0;
        bus.mem_stall   = 1'b0;
        bus2.id_valid = 1'b0; bus2.id_rs = 3'd0; bus2.id_rt = 3'd0;
        bus2.id_rs_used = 1'b0; bus2.id_rt_used = 1'b0; bus2.id_rd = 3'd0;
        bus2.id_wr = 1'b0; bus2.id_load = 1'b0; bus2.id_ctrl = 1'b0;
        bus2.ex_redirect = 1'b0; bus2.mem_stall = 1'b0;
        step();

        // Small-counter instance: stall held, counter must pin at 7.
        rst2 = 1'b1;
        bus2.mem_stall = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("sat_stall_cnt", bus2.stall_cnt, (k < 7) ? k : 7);
        end
        chk("sat_flush_cnt", bus2.flush_cnt, 0);
        bus2.mem_stall = 1'b0;

        // Reset state.
        settle();
        chk("rst_stall_id", bus.stall_id, 0);
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        rst = 1'b1;

        // Load rd=3 then add using rs=3.
        issue(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0);
        step();
        issue(1, 3'd3, 3'd0, 1, 0, 3'd4, 1, 0, 0);
        settle();
        chk("lu_stall_on", bus.stall_id, 1);
        step();
        settle();
        chk("lu_stall_off", bus.stall_id, 0);
        chk("lu_bubble", bus.ex_valid, 0);
        step();
        nop();
        settle();
        chk("lu_add_in_ex", bus.ex_valid, 1);
        chk("lu_fwd_a", bus.fwd_a, 2'b10);
        chk("lu_stall_cnt", bus.stall_cnt, 1);

        // Forwarding distances.
        issue(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0);
        step();
        issue(1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0);
        settle();
        chk("fwd_no_stall", bus.stall_id, 0);
        step();
        settle();
        chk("fwd_b_ex", bus.fwd_b, 2'b01);
        issue(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0);
        step();
        issue(1, 3'd0, 3'd0, 0, 0, 3'd7, 1, 0, 0);
        step();
        issue(1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0);
        step();
        settle();
        chk("fwd_b_mem", bus.fwd_b, 2'b10);
        issue(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0);
        step();
        issue(1, 3'd2, 3'd0, 0, 0, 3'd6, 1, 0, 0);
        step();
        settle();
        chk("fwd_a_unused", bus.fwd_a, 2'b00);

        // Redirect from a branch, then from a non-ctrl op.
        issue(1, 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1);
        step();
        issue(1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0);
        bus.ex_redirect = 1'b1;
        settle();
        chk("redir_flush", bus.flush, 1);
        step();
        bus.ex_redirect = 1'b0;
        nop();
        settle();
        chk("redir_flush_off", bus.flush, 0);
        chk("redir_bubble", bus.ex_valid, 0);
        chk("redir_flush_cnt", bus.flush_cnt, 1);
        issue(1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0);
        step();
        nop();
        bus.ex_redirect = 1'b1;
        settle();
        chk("redir_nonctrl", bus.flush, 0);
        bus.ex_redirect = 1'b0;

        // Memory stall for three cycles with a branch in EX.
        issue(1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0);
        step();
        issue(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0);
        step();
        issue(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 0, 1);
        step();
        nop();
        bus.mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.ex_redirect = (k == 1);
            settle();
            chk("ms_stall_id", bus.stall_id, 1);
            chk("ms_wb_wr", bus.wb_wr, 0);
            chk("ms_wb_rd", bus.wb_rd, 3'd1);
            chk("ms_valids", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b111);
            if (k == 1) chk("ms_no_flush", bus.flush, 0);
            step();
        end
        bus.mem_stall = 1'b0;
        bus.ex_redirect = 1'b0;
        settle();
        chk("ms_stall_cnt", bus.stall_cnt, 4);
        chk("ms_resume_rd", bus.wb_rd, 3'd1);
        chk("ms_resume_wr", bus.wb_wr, 1);
        step();
        settle();
        chk("ms_advance_rd", bus.wb_rd, 3'd2);

        // Redirect coincident with load-use.
        issue(1, 3'd0, 3'd0, 0, 0, 3'd5, 1, 1, 1);
        step();
        issue(1, 3'd5, 3'd0, 1, 0, 3'd6, 1, 0, 0);
        bus.ex_redirect = 1'b1;
        settle();
        chk("co_flush", bus.flush, 1);
        chk("co_stall_id", bus.stall_id, 0);
        step();
        bus.ex_redirect = 1'b0;

        // Mid-stream reset.
        issue(1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0);
        step();
        issue(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0);
        step();
        issue(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 0, 0);
        step();
        nop();
        settle();
        chk("pre_rst_full", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b111);
        rst = 1'b0;
        step();
        rst = 1'b1;
        settle();
        chk("post_rst_ctl", {bus.stall_id, bus.flush, bus.wb_wr}, 3'b000);
        chk("post_rst_valid", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b000);
        chk("post_rst_fwd", {bus.fwd_a, bus.fwd_b, bus.wb_rd}, 7'd0);
        chk("post_rst_cnt", {bus.stall_cnt, bus.flush_cnt}, 32'd0);

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 1500; i++) begin
            step();
            rst             = ($urandom_range(0, 60) != 0);
            bus.mem_stall   = ($urandom_range(0, 5) == 0);
            bus.ex_redirect = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                issue(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
                      3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 3) == 0));
            end
        end
        step();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL expose parameter CNTW, default 16, width of the stall and flush event counters.
REQ-002 SHALL expose ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on clk only.
- id_valid  in  1  decode holds a real instruction.
- id_rs, id_rt  in  3 each  source register numbers.
- id_rs_used, id_rt_used  in  1 each  source is actually read.
- id_rd  in  3  destination register.
- id_wr  in  1  instruction writes id_rd.
- id_load  in  1  instruction is a load.
- id_ctrl  in  1  instruction is a branch or jump.
- ex_redirect  in  1  execute resolved a taken branch or jump (PCwb differs from sequential PC).
- mem_stall  in  1  memory stage busy.
- stall_id  out  1  hold PC and IF/ID latch.
- flush  out  1  squash instruction in IF/ID.
- ex_valid, mem_valid, wb_valid  out  1 each  stage occupancy.
- fwd_a, fwd_b  out  2 each  execute operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- wb_rd  out  3; wb_wr  out  1  register-file write control.
- stall_cnt, flush_cnt  out  CNTW each  event counters.

Function
REQ-003 SHALL keep a shadow record {valid, rd, wr, load, ctrl} for each of EX, MEM and WB, and shall hold fwd_a/fwd_b as registered EX-stage state.
REQ-004 Normal advance (no stall, no flush), per edge: ID->EX, EX->MEM, MEM->WB, with EX.valid <= id_valid.
REQ-005 Load-use hazard, defined as id_valid & EX.valid & EX.load & EX.wr & ((id_rs_used & id_rs==EX.rd) | (id_rt_used & id_rt==EX.rd)): SHALL assert stall_id combinationally and insert a bubble (EX.valid<=0) while MEM/WB advance; the hazard lasts exactly one cycle.
REQ-006 Redirect, defined as ex_redirect & EX.valid & EX.ctrl: SHALL assert flush combinationally and load a bubble into EX at the next edge; ex_redirect is ignored when EX.valid=0 or EX.ctrl=0.
REQ-007 mem_stall=1: SHALL freeze EX, MEM, WB, fwd_a and fwd_b; SHALL assert stall_id; SHALL force flush=0; SHALL force wb_wr=0.
REQ-008 Priority: mem_stall > redirect > load-use; on a simultaneous redirect and load-use only flush is asserted and stall_id=0.
REQ-009 Forwarding selects are computed when an instruction enters EX and registered with it:
- fwd_a=01 if EX.valid & EX.wr & !EX.load & id_rs==EX.rd;
- else fwd_a=10 if MEM.valid & MEM.wr & id_rs==MEM.rd;
- else fwd_a=00.
- Nearer stage wins.
- Same rules for fwd_b using id_rt.
- fwd_x is forced to 00 when the corresponding _used input is 0.
- fwd_x is forced to 00 on a bubble.
REQ-010 Register 0 SHALL be treated as an ordinary register, with no zero-register exclusion.
REQ-011 Outputs: ex_valid=EX.valid, mem_valid=MEM.valid, wb_valid=WB.valid, wb_rd=WB.rd, wb_wr=WB.valid & WB.wr & !mem_stall.
REQ-012 stall_cnt SHALL increment by 1 on each cycle that stall_id=1 due to load-use or mem_stall.
REQ-013 flush_cnt SHALL increment by 1 on each cycle that flush=1.
REQ-014 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-015 While rst=0 at an edge, the block SHALL clear all stage valids, rd/wr/load/ctrl fields, fwd_a, fwd_b and both counters to 0.
REQ-016 After such an edge, stall_id=0, flush=0 and wb_wr=0.
REQ-017 Reset SHALL override mem_stall, redirect and hazards in the same cycle.
REQ-018 An instruction in flight during a mid-operation reset SHALL be discarded.

Verification
REQ-019 Bench: load rd=3 issued, followed by an add with rs=3 used -> stall_id=1 for exactly 1 cycle, one bubble seen in EX, fwd_a=10 when the add enters EX, stall_cnt=1.
REQ-020 Bench: add rd=2 followed immediately by sub rt=2 used -> no stall, fwd_b=01; with one unrelated instruction between them -> fwd_b=10; with rs=2 but id_rs_used=0 -> fwd_a=00.
REQ-021 Bench: branch in EX with ex_redirect=1 -> flush=1 for 1 cycle, EX.valid=0 next cycle, flush_cnt=1; ex_redirect=1 with a non-ctrl op in EX -> flush=0.
REQ-022 Bench: mem_stall held 3 cycles mid-stream -> all stage outputs constant, wb_wr=0, stall_id=1, stall_cnt+=3, pipeline resumes unchanged after release; redirect asserted during the stall -> flush=0.
REQ-023 Bench: redirect coincident with load-use -> flush=1, stall_id=0; counter preset near all-ones with stall forced -> holds at all-ones.
REQ-024 Bench: rst=0 for 1 cycle with three valid stages and nonzero counters -> every output 0 at the next cycle.
